// File: rtl/jpeg_pkg.sv
// Shared defaults and state encoding for the JPEG pipeline frame sequencer.
package jpeg_pkg;

  localparam int unsigned DEF_ADDR_W   = 15;
  localparam int unsigned DEF_BLK_ROWS = 8;
  localparam int unsigned DEF_PIPE_LAT = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/jpeg_valid_delay.sv
// Fixed-depth single-bit delay line: o_q(t) = i_d(t-DEPTH), with synchronous flush.
module jpeg_valid_delay #(
  parameter int unsigned DEPTH = 40
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/jpeg_pipe_ctrl.sv
// Frame sequencer: issues input row reads, tracks pipeline latency to flag
// valid output rows, and holds the datapath in reset between frames.
module jpeg_pipe_ctrl
  import jpeg_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned BLK_ROWS = DEF_BLK_ROWS,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [ADDR_W-$clog2(BLK_ROWS)-1:0]   num_blocks,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pipe_rst_n,
  output logic [ADDR_W-1:0]                    cnt,
  output logic                                 rd_en,
  output logic [ADDR_W-1:0]                    rd_addr,
  output logic                                 wr_en,
  output logic [ADDR_W-1:0]                    wr_addr
);

  localparam int unsigned BLK_SHIFT = $clog2(BLK_ROWS);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_total;
  logic                r_busy;
  logic                r_done;
  logic                r_pipe_rst_n;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr;

  logic [ADDR_W-1:0]   w_total;
  logic [ADDR_W-1:0]   w_last;
  logic                w_wr_en;
  logic                w_wr_final;

  assign w_total    = ADDR_W'(num_blocks) << BLK_SHIFT;
  assign w_last     = r_total - ADDR_W'(1);
  assign w_wr_final = w_wr_en && (r_wr_addr == w_last);

  // Delay line is flushed on abort so no stale rows surface in a later frame.
  jpeg_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (abort),
    .i_d     (r_rd_en),
    .o_q     (w_wr_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_total      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pipe_rst_n <= 1'b0;
      r_cnt        <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state      <= ST_IDLE;
        r_busy       <= 1'b0;
        r_pipe_rst_n <= 1'b0;
        r_cnt        <= '0;
        r_rd_en      <= 1'b0;
        r_rd_addr    <= '0;
        r_wr_addr    <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (num_blocks != '0) begin
                r_total      <= w_total;
                r_state      <= ST_RUN;
                r_busy       <= 1'b1;
                r_pipe_rst_n <= 1'b1;
                r_rd_en      <= 1'b1;
                r_cnt        <= '0;
                r_rd_addr    <= '0;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            r_cnt <= r_cnt + ADDR_W'(1);
            // Last read leaves rd_addr parked on the final row.
            if (r_rd_addr == w_last) begin
              r_rd_en <= 1'b0;
              r_state <= ST_DRAIN;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
          ST_DRAIN: begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase

        // Output-row tracking overrides the state step on the final row.
        if (w_wr_final) begin
          r_done       <= 1'b1;
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_pipe_rst_n <= 1'b0;
          r_cnt        <= '0;
          r_rd_en      <= 1'b0;
          r_rd_addr    <= '0;
          r_wr_addr    <= '0;
        end else if (w_wr_en) begin
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pipe_rst_n = r_pipe_rst_n;
  assign cnt        = r_cnt;
  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign wr_en      = w_wr_en;
  assign wr_addr    = r_wr_addr;

endmodule

// File: tb/tb_jpeg_pipe_ctrl.sv
// Scoreboard bench for jpeg_pipe_ctrl: commands schedule expected row reads,
// row writes and done pulses by cycle number; a negedge monitor retires them.
module tb_jpeg_pipe_ctrl;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned BLK_ROWS = 8;
  localparam int unsigned PIPE_LAT = 40;
  localparam int unsigned NB_W     = ADDR_W - 3;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [NB_W-1:0]   num_blocks;
  logic              busy;
  logic              done;
  logic              pipe_rst_n;
  logic [ADDR_W-1:0] cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  jpeg_pipe_ctrl #(
    .ADDR_W   (ADDR_W),
    .BLK_ROWS (BLK_ROWS),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .num_blocks (num_blocks),
    .busy       (busy),
    .done       (done),
    .pipe_rst_n (pipe_rst_n),
    .cnt        (cnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int cyc;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_wr[$];
  int  q_done[$];
  int  busy_from = 1;
  int  busy_to   = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endfunction

  // Reference model: a frame of nb blocks is a list of timed row events.
  function automatic void model_cmd(input bit st, input bit ab, input int nb);
    int k;
    int s;
    int total;
    ev_t tmp[$];
    int  tmpd[$];
    k = cyc;
    if (ab) begin
      if (busy_to > k) busy_to = k;
      tmp = {};
      foreach (q_rd[i]) if (q_rd[i].cyc <= k) tmp.push_back(q_rd[i]);
      q_rd = tmp;
      tmp = {};
      foreach (q_wr[i]) if (q_wr[i].cyc <= k) tmp.push_back(q_wr[i]);
      q_wr = tmp;
      tmpd = {};
      foreach (q_done[i]) if (q_done[i] <= k) tmpd.push_back(q_done[i]);
      q_done = tmpd;
    end else if (st && !(busy_from <= k && k <= busy_to)) begin
      s = k + 1;
      if (nb == 0) begin
        q_done.push_back(s);
      end else begin
        total     = nb * BLK_ROWS;
        busy_from = s;
        busy_to   = s + PIPE_LAT + total - 1;
        for (int i = 0; i < total; i++) begin
          q_rd.push_back('{addr: i, cyc: s + i});
          q_wr.push_back('{addr: i, cyc: s + PIPE_LAT + i});
        end
        q_done.push_back(s + PIPE_LAT + total);
      end
    end
  endfunction

  task automatic step(input bit st, input bit ab, input int nb);
    @(posedge clk);
    #2;
    start      = st;
    abort      = ab;
    num_blocks = NB_W'(nb);
    model_cmd(st, ab, nb);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    logic              exp_busy;
    logic [ADDR_W-1:0] exp_cnt;
    logic              exp_rd;
    logic              exp_wr;
    logic              exp_done;
    ev_t               ev;
    exp_busy = (busy_from <= cyc) && (cyc <= busy_to);
    exp_cnt  = exp_busy ? ADDR_W'(cyc - busy_from) : '0;
    check("busy", busy, exp_busy);
    check("pipe_rst_n", pipe_rst_n, exp_busy);
    check("cnt", cnt, exp_cnt);
    if (!exp_busy) begin
      check("rd_addr_idle", rd_addr, 0);
      check("wr_addr_idle", wr_addr, 0);
    end

    exp_rd = (q_rd.size() != 0) && (q_rd[0].cyc <= cyc);
    check("rd_en", rd_en, exp_rd);
    if ((rd_en || exp_rd) && q_rd.size() != 0) begin
      ev = q_rd.pop_front();
      if (rd_en) begin
        check("rd_addr", rd_addr, ev.addr);
        check("rd_cycle", cyc, ev.cyc);
      end
    end

    exp_wr = (q_wr.size() != 0) && (q_wr[0].cyc <= cyc);
    check("wr_en", wr_en, exp_wr);
    if ((wr_en || exp_wr) && q_wr.size() != 0) begin
      ev = q_wr.pop_front();
      if (wr_en) begin
        check("wr_addr", wr_addr, ev.addr);
        check("wr_cycle", cyc, ev.cyc);
      end
    end

    exp_done = (q_done.size() != 0) && (q_done[0] <= cyc);
    check("done", done, exp_done);
    if ((done || exp_done) && q_done.size() != 0) void'(q_done.pop_front());
  end

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    num_blocks = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;

    idle(10);

    step(1'b1, 1'b0, 1);
    idle(60);

    step(1'b1, 1'b0, 3);
    idle(80);

    step(1'b1, 1'b0, 0);
    idle(5);

    step(1'b1, 1'b0, 2);
    idle(5);
    step(1'b0, 1'b1, 0);
    idle(60);
    step(1'b1, 1'b0, 1);
    idle(60);

    step(1'b1, 1'b0, 2);
    idle(3);
    step(1'b1, 1'b0, 5);
    idle(30);
    step(1'b1, 1'b0, 3);
    idle(80);

    step(1'b1, 1'b0, 8);
    idle(50);
    step(1'b1, 1'b1, 4);
    idle(60);

    for (int i = 0; i < 3000; i++) begin
      bit st;
      bit ab;
      int nb;
      st = ($urandom_range(0, 9) == 0);
      ab = ($urandom_range(0, 149) == 0);
      nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 4));
      step(st, ab, nb);
    end

    idle(PIPE_LAT + 120);

    check("rd_left", q_rd.size(), 0);
    check("wr_left", q_wr.size(), 0);
    check("done_left", q_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
